// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_t : REQ  - a request may be issued to instruction memory
//                   WAIT - one request outstanding, waiting for its response
//                   HOLD - instruction held for decode until it is accepted
//   INST_BYTES    : PC increment for a sequential instruction
//   NOP_INST      : canonical no-op encoding (addi x0, x0, 0)
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int unsigned INST_BYTES = 32'd4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

endpackage

// File: rtl/fetch_next_pc.sv
// -----------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC select with priority
//   trap > redirect > sequential advance > hold.
// Redirect/trap targets are word aligned (bits [1:0] cleared) before use.
// Ports:
//   pc_i             current fetch PC
//   advance_i        held instruction accepted, step to the next sequential PC
//   trap_valid_i     trap entry request
//   trap_pc_i        trap vector
//   redirect_valid_i branch/jump taken
//   redirect_pc_i    branch/jump target
//   next_pc_o        selected next PC
//   redirect_o       a trap or redirect is active this cycle
// -----------------------------------------------------------------------------
module fetch_next_pc #(
    parameter int unsigned n          = 32,
    parameter int unsigned INST_BYTES = 4
) (
    input  logic [n-1:0] pc_i,
    input  logic         advance_i,
    input  logic         trap_valid_i,
    input  logic [n-1:0] trap_pc_i,
    input  logic         redirect_valid_i,
    input  logic [n-1:0] redirect_pc_i,
    output logic [n-1:0] next_pc_o,
    output logic         redirect_o
);

    // Priority select of the next fetch address
    always_comb begin
        next_pc_o  = pc_i;
        redirect_o = 1'b0;
        if (trap_valid_i) begin
            next_pc_o  = {trap_pc_i[n-1:2], 2'b00};
            redirect_o = 1'b1;
        end else if (redirect_valid_i) begin
            next_pc_o  = {redirect_pc_i[n-1:2], 2'b00};
            redirect_o = 1'b1;
        end else if (advance_i) begin
            // Plain n-bit addition, so the top word wraps to address 0
            next_pc_o  = pc_i + n'(INST_BYTES);
            redirect_o = 1'b0;
        end else begin
            next_pc_o  = pc_i;
            redirect_o = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the PC, issues one outstanding request at a time to a req/gnt/rvalid
// instruction memory, holds the returned word until decode accepts it, and
// applies trap/redirect changes of flow, discarding stale instructions.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   fetch_en                         allows new memory requests
//   redirect_valid/redirect_pc       branch/jump from execute
//   trap_valid/trap_pc               trap entry (wins over redirect)
//   imem_req/imem_addr               memory request and address (= pc_o)
//   imem_gnt/imem_rvalid/imem_rdata  memory grant and response
//   inst_valid/inst_o/inst_pc        held instruction towards decode
//   inst_ready                       decode accepts the held instruction
//   pc_o                             current fetch PC
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned    n          = 32,
    parameter logic [n-1:0]   RESET_PC   = {n{1'b0}},
    parameter int unsigned    INST_BYTES = fetch_pkg::INST_BYTES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fetch_en,
    input  logic         redirect_valid,
    input  logic [n-1:0] redirect_pc,
    input  logic         trap_valid,
    input  logic [n-1:0] trap_pc,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic         inst_valid,
    output logic [31:0]  inst_o,
    output logic [n-1:0] inst_pc,
    input  logic         inst_ready,
    output logic [n-1:0] pc_o
);

    import fetch_pkg::fetch_state_t;
    import fetch_pkg::REQ;
    import fetch_pkg::WAIT;
    import fetch_pkg::HOLD;

    fetch_state_t state_q, state_d;
    logic [n-1:0] pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         inst_valid_q, inst_valid_d;
    logic [31:0]  inst_q, inst_d;
    logic [n-1:0] inst_pc_q, inst_pc_d;

    logic         req_s;
    logic         advance_s;
    logic         redir_s;
    logic [n-1:0] next_pc_s;

    // Request and handshake qualifiers
    assign req_s     = (state_q == REQ) && fetch_en && !reset;
    assign advance_s = (state_q == HOLD) && inst_ready;

    fetch_next_pc #(
        .n          (n),
        .INST_BYTES (INST_BYTES)
    ) u_next_pc (
        .pc_i             (pc_q),
        .advance_i        (advance_s),
        .trap_valid_i     (trap_valid),
        .trap_pc_i        (trap_pc),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .next_pc_o        (next_pc_s),
        .redirect_o       (redir_s)
    );

    // Next-state logic for the fetch FSM and its datapath registers
    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        // advance_s is only raised in HOLD, so next_pc_s equals pc_q
        // everywhere except on a redirect or an accepted instruction.
        pc_d         = next_pc_s;
        case (state_q)
            REQ: begin
                if (req_s && imem_gnt) begin
                    // A redirect in the grant cycle leaves a request for the
                    // old PC in flight; its response must be dropped.
                    state_d = WAIT;
                    kill_d  = redir_s;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redir_s) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d       = imem_rdata;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end else if (redir_s) begin
                    kill_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                // Redirect and handshake both release the held word; the PC
                // choice between them is made in fetch_next_pc.
                if (redir_s || inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d      = REQ;
                kill_d       = 1'b0;
                inst_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= {n{1'b0}};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign imem_req   = req_s;
    assign imem_addr  = pc_q;
    assign pc_o       = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst_o     = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed scenarios followed by randomized traffic. A transaction-level
// reference (outstanding / stale / held flags plus PC) predicts the outputs.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_o;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] pc_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_stale;
    logic        m_held;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;

    // Bench memory environment
    logic        mem_busy;
    int          mem_lat;
    logic [31:0] mem_word;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_o         (inst_o),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .pc_o           (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_req();
        return fetch_en && !reset && !m_held && !m_out;
    endfunction

    // One clock: check request, clock, advance the model, check state outputs
    task automatic step();
        logic        redir;
        logic [31:0] tgt;
        logic        ereq;
        #1;
        redir = trap_valid | redirect_valid;
        tgt   = (trap_valid ? trap_pc : redirect_pc) & 32'hFFFF_FFFC;
        ereq  = model_req();
        chk("imem_req", {31'd0, imem_req}, {31'd0, ereq});
        chk("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        #1;
        if (reset) begin
            m_pc = 32'h0000_0000; m_out = 1'b0; m_stale = 1'b0;
            m_held = 1'b0; m_inst = 32'h0; m_ipc = 32'h0;
        end else if (m_held) begin
            if (redir) begin
                m_held = 1'b0; m_pc = tgt;
            end else if (inst_ready) begin
                m_held = 1'b0; m_pc = m_pc + 32'd4;
            end
        end else if (m_out) begin
            if (redir) begin
                m_pc = tgt;
                if (imem_rvalid) begin
                    m_out = 1'b0; m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end else if (imem_rvalid) begin
                m_out = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    m_held = 1'b1; m_inst = imem_rdata; m_ipc = m_pc;
                end
            end
        end else begin
            if (ereq && imem_gnt) begin
                m_out = 1'b1;
                if (redir) begin
                    m_stale = 1'b1; m_pc = tgt;
                end
            end else if (redir) begin
                m_pc = tgt;
            end
        end
        chk("pc_o", pc_o, m_pc);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_held});
        if (m_held) begin
            chk("inst_o", inst_o, m_inst);
            chk("inst_pc", inst_pc, m_ipc);
        end
    endtask

    task automatic quiet();
        redirect_valid = 1'b0; trap_valid = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    endtask

    initial begin
        m_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0;
        m_inst = 32'h0; m_ipc = 32'h0;
        mem_busy = 1'b0; mem_lat = 0; mem_word = 32'h0;
        reset = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1;
        redirect_pc = 32'h0; trap_pc = 32'h0;
        quiet();

        // Reset state; imem_req must stay low while reset is high
        step(); step();
        chk("rst_pc", pc_o, 32'h0000_0000);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst_o", inst_o, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        // T1: basic fetch, rvalid two cycles after gnt
        reset = 1'b0; imem_gnt = 1'b1;
        step();
        quiet(); step();
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; step();
        chk("t1_valid", {31'd0, inst_valid}, 32'd1);
        chk("t1_inst", inst_o, 32'h0050_0093);
        chk("t1_ipc", inst_pc, 32'h0);
        quiet(); step();
        chk("t1_next_addr", imem_addr, 32'h4);

        // T2: back-pressure with a stray rvalid while holding
        imem_gnt = 1'b1; step();
        quiet(); imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; step();
        quiet(); inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            imem_rvalid = (i == 2) ? 1'b1 : 1'b0;
            imem_gnt = 1'b1;
            step();
            chk("t2_hold_inst", inst_o, 32'h1234_5678);
            chk("t2_hold_pc", inst_pc, 32'h4);
        end
        quiet(); inst_ready = 1'b1; step();
        chk("t2_next_addr", imem_addr, 32'h8);

        // T3: redirect while waiting discards the response
        imem_gnt = 1'b1; step();
        quiet(); redirect_valid = 1'b1; redirect_pc = 32'h100; step();
        quiet(); imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001; step();
        chk("t3_valid", {31'd0, inst_valid}, 32'd0);
        chk("t3_addr", imem_addr, 32'h100);

        // T4: trap beats redirect and the handshake in HOLD
        quiet(); imem_gnt = 1'b1; step();
        quiet(); imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; step();
        quiet(); trap_valid = 1'b1; trap_pc = 32'h80;
        redirect_valid = 1'b1; redirect_pc = 32'h200; step();
        chk("t4_valid", {31'd0, inst_valid}, 32'd0);
        chk("t4_pc", pc_o, 32'h80);
        quiet(); #1;
        chk("t4_req", {31'd0, imem_req}, 32'd1);

        // T5: redirect in the grant cycle, unaligned target
        imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103; step();
        quiet(); imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002; step();
        chk("t5_valid", {31'd0, inst_valid}, 32'd0);
        chk("t5_addr", imem_addr, 32'h100);

        // T6: PC wrap, then reset during WAIT
        quiet(); fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; step();
        quiet(); fetch_en = 1'b1; imem_gnt = 1'b1; step();
        quiet(); imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0013; step();
        chk("t6_ipc", inst_pc, 32'hFFFF_FFFC);
        quiet(); step();
        chk("t6_wrap_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1; step();
        quiet(); reset = 1'b1; step();
        chk("t6_rst_pc", pc_o, 32'h0);
        chk("t6_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b0;

        // Randomized traffic against the bench memory model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic acc;
            reset          = ($urandom_range(0, 199) == 0);
            fetch_en       = ($urandom_range(0, 9) != 0);
            inst_ready     = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            trap_valid     = ($urandom_range(0, 49) == 0);
            trap_pc        = $urandom;
            imem_gnt       = $urandom_range(0, 1);
            imem_rvalid    = mem_busy && (mem_lat == 0) && !reset;
            imem_rdata     = imem_rvalid ? mem_word : $urandom;
            acc            = model_req() && imem_gnt;
            step();
            if (reset) begin
                mem_busy = 1'b0;
            end else if (imem_rvalid) begin
                mem_busy = 1'b0;
            end else if (mem_busy && mem_lat > 0) begin
                mem_lat--;
            end
            if (acc) begin
                mem_busy = 1'b1;
                mem_lat  = $urandom_range(0, 2);
                mem_word = $urandom;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
